// File: rtl/pipe_stage_chain_if.sv
// pipe_stage_chain_if: producer/consumer ready/valid bundle.
// master = the surrounding logic, slave = the pipeline chain.
interface pipe_stage_chain_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: parametrised pipeline register chain with
// per-stage stall/flush, rigid or bubble-collapsing back-pressure.
module pipe_stage_chain #(
    parameter int WIDTH    = 32,
    parameter int STAGES   = 4,
    parameter int COLLAPSE = 0,
    parameter int CNT_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    pipe_stage_chain_if.slave           bus,
    input  logic [STAGES-1:0]           stall,
    input  logic [STAGES-1:0]           flush,
    output logic [STAGES-1:0]           stage_valid,
    output logic [STAGES*WIDTH-1:0]     stage_data,
    output logic [$clog2(STAGES+1)-1:0] occupancy,
    output logic [CNT_W-1:0]            kill_cnt
);
    localparam int OW = $clog2(STAGES + 1);

    logic [STAGES-1:0]            valid_q;
    logic [STAGES-1:0][WIDTH-1:0] data_q;
    logic [STAGES-1:0]            blocked;
    logic [STAGES-1:0]            inc_v;
    logic [STAGES-1:0][WIDTH-1:0] inc_d;
    logic [OW-1:0]                kills;
    logic [CNT_W-1:0]             kill_nxt;

    // Back-pressure chain, resolved from the oldest stage down to stage 0.
    always_comb begin
        logic blk;
        blocked = '0;
        if (COLLAPSE != 0)
            blk = stall[STAGES-1] | (valid_q[STAGES-1] & ~bus.out_ready);
        else
            blk = stall[STAGES-1] | ~bus.out_ready;
        blocked[STAGES-1] = blk;
        for (int i = STAGES - 2; i >= 0; i--) begin
            if (COLLAPSE != 0)
                blk = stall[i] | (valid_q[i] & blk);
            else
                blk = stall[i] | blk;
            blocked[i] = blk;
        end
    end

    // Item each stage would take; a blocked feeder hands over a bubble.
    always_comb begin
        inc_v    = '0;
        inc_d    = '0;
        inc_v[0] = bus.in_valid;
        inc_d[0] = bus.in_data;
        for (int i = 1; i < STAGES; i++) begin
            inc_v[i] = valid_q[i-1] & ~blocked[i-1];
            inc_d[i] = data_q[i-1];
        end
    end

    // Valid items destroyed this cycle, added to a saturating total.
    always_comb begin
        logic [CNT_W:0] sum;
        kills = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (flush[i] && (blocked[i] ? valid_q[i] : inc_v[i]))
                kills = kills + OW'(1);
        end
        sum      = {1'b0, kill_cnt} + (CNT_W + 1)'(kills);
        kill_nxt = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end

    // Stage registers: flush beats hold, hold beats advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= '0;
            data_q   <= '0;
            kill_cnt <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (flush[i]) begin
                    valid_q[i] <= 1'b0;
                    data_q[i]  <= '0;
                end else if (!blocked[i]) begin
                    valid_q[i] <= inc_v[i];
                    data_q[i]  <= inc_v[i] ? inc_d[i] : '0;
                end
            end
            kill_cnt <= kill_nxt;
        end
    end

    // Occupancy is the population count of the valid bits.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < STAGES; i++)
            occupancy = occupancy + OW'(valid_q[i]);
    end

    assign stage_valid   = valid_q;
    assign stage_data    = data_q;
    assign bus.in_ready  = ~blocked[0];
    assign bus.out_valid = valid_q[STAGES-1] & ~stall[STAGES-1];
    assign bus.out_data  = data_q[STAGES-1];
endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: directed and randomised checks of the chain
// against an ordering/conservation scoreboard and a ready model.
module tb_pipe_stage_chain;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_stage_chain_if #(.WIDTH(8)) bus_r ();
    pipe_stage_chain_if #(.WIDTH(8)) bus_c ();
    pipe_stage_chain_if #(.WIDTH(8)) bus_s ();

    logic [3:0]  st_r, fl_r, sv_r, st_c, fl_c, sv_c, st_s, fl_s, sv_s;
    logic [31:0] sd_r, sd_c, sd_s;
    logic [2:0]  occ_r, occ_c, occ_s;
    logic [15:0] kc_r, kc_c;
    logic [3:0]  kc_s;

    pipe_stage_chain #(.WIDTH(8), .STAGES(4), .COLLAPSE(0), .CNT_W(16)) u_r (
        .clk(clk), .rst(rst), .bus(bus_r), .stall(st_r), .flush(fl_r),
        .stage_valid(sv_r), .stage_data(sd_r), .occupancy(occ_r),
        .kill_cnt(kc_r)
    );
    pipe_stage_chain #(.WIDTH(8), .STAGES(4), .COLLAPSE(1), .CNT_W(16)) u_c (
        .clk(clk), .rst(rst), .bus(bus_c), .stall(st_c), .flush(fl_c),
        .stage_valid(sv_c), .stage_data(sd_c), .occupancy(occ_c),
        .kill_cnt(kc_c)
    );
    pipe_stage_chain #(.WIDTH(8), .STAGES(4), .COLLAPSE(0), .CNT_W(4)) u_s (
        .clk(clk), .rst(rst), .bus(bus_s), .stall(st_s), .flush(fl_s),
        .stage_valid(sv_s), .stage_data(sd_s), .occupancy(occ_s),
        .kill_cnt(kc_s)
    );

    int errs = 0;
    int nchk = 0;
    logic [8:0] sbq[$];
    int acc[2];
    int dlv[2];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic mon(input int id, input string nm, input bit col,
                       input logic iv, input logic [7:0] idt,
                       input logic ir, input logic ov,
                       input logic [7:0] od, input logic ordy,
                       input logic [3:0] st, input logic [3:0] sv,
                       input logic [31:0] sd, input logic [2:0] occ,
                       input logic [15:0] kc);
        logic        exp_ir;
        bit          done;
        bit          bz;
        bit          hit;
        int          j;
        logic [31:0] got;
        if (!rst) begin
            for (int i = sbq.size() - 1; i >= 0; i--)
                if (sbq[i][8] == 1'(id)) sbq.delete(i);
            acc[id] = 0;
            dlv[id] = 0;
            return;
        end
        chk({nm, "_occ"}, {29'h0, occ}, $countones(sv));
        chk({nm, "_conserve"}, {29'h0, occ}, acc[id] - dlv[id] - int'(kc));
        bz = 1'b0;
        for (int i = 0; i < 4; i++)
            if (!sv[i] && sd[i*8 +: 8] != 8'h00) bz = 1'b1;
        chk({nm, "_bubble_zero"}, {31'h0, bz}, 0);
        chk({nm, "_out_valid"}, {31'h0, ov}, {31'h0, sv[3] & ~st[3]});
        chk({nm, "_out_data"}, {24'h0, od}, {24'h0, sd[31:24]});
        exp_ir = ordy;
        done   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!done) begin
                if (st[i]) begin
                    exp_ir = 1'b0;
                    done   = 1'b1;
                end else if (col && !sv[i]) begin
                    exp_ir = 1'b1;
                    done   = 1'b1;
                end
            end
        end
        chk({nm, "_in_ready"}, {31'h0, ir}, {31'h0, exp_ir});
        if (ov && ordy) begin
            dlv[id]++;
            got = 32'hFFFF_FFFF;
            hit = 1'b0;
            j   = 0;
            while (!hit && j < sbq.size()) begin
                if (sbq[j][8] != 1'(id)) begin
                    j++;
                end else begin
                    got = {24'h0, sbq[j][7:0]};
                    sbq.delete(j);
                    hit = (got[7:0] == od);
                end
            end
            chk({nm, "_sb_order"}, {24'h0, od}, got);
        end
        if (iv && ir) begin
            sbq.push_back({1'(id), idt});
            acc[id]++;
        end
    endtask

    always @(negedge clk) begin
        #2;
        mon(0, "rigid", 1'b0, bus_r.in_valid, bus_r.in_data, bus_r.in_ready,
            bus_r.out_valid, bus_r.out_data, bus_r.out_ready,
            st_r, sv_r, sd_r, occ_r, kc_r);
        mon(1, "collapse", 1'b1, bus_c.in_valid, bus_c.in_data,
            bus_c.in_ready, bus_c.out_valid, bus_c.out_data,
            bus_c.out_ready, st_c, sv_c, sd_c, occ_c, kc_c);
    end

    initial begin
        int       idx;
        logic     v;
        logic     ordy;
        logic [7:0] tag_r;
        logic [7:0] tag_c;
        bus_r.in_valid = 0; bus_r.in_data = 0; bus_r.out_ready = 1;
        bus_c.in_valid = 0; bus_c.in_data = 0; bus_c.out_ready = 1;
        bus_s.in_valid = 0; bus_s.in_data = 0; bus_s.out_ready = 1;
        st_r = 0; fl_r = 0; st_c = 0; fl_c = 0; st_s = 0; fl_s = 0;

        @(negedge clk); #1;
        chk("rst_valid", {28'h0, sv_r}, 0);
        chk("rst_kill", {16'h0, kc_r}, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_out_valid", {31'h0, bus_r.out_valid}, 0);
        chk("rst_occ", {29'h0, occ_r}, 0);

        // streaming latency and order
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            bus_r.in_valid = (k < 8);
            bus_r.in_data  = 8'(k + 1);
            #1;
            if (k < 8) chk("t1_in_ready", {31'h0, bus_r.in_ready}, 1);
            chk("t1_out_valid", {31'h0, bus_r.out_valid}, (k >= 4) ? 1 : 0);
            if (k >= 4) chk("t1_out_data", {24'h0, bus_r.out_data}, k - 3);
            chk("t1_occ", {29'h0, occ_r},
                (k <= 4) ? k : ((k <= 8) ? 4 : 12 - k));
        end

        // stall on stage 1 for two cycles
        idx = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            bus_r.in_valid = (idx < 8);
            bus_r.in_data  = 8'(8'h11 + idx);
            st_r = (k == 3 || k == 4) ? 4'b0010 : 4'b0000;
            #1;
            if (k == 3 || k == 4)
                chk("t2_in_ready", {31'h0, bus_r.in_ready}, 0);
            if (k == 4 || k == 5) begin
                chk("t2_hold_s0", {24'h0, sd_r[7:0]}, 32'h13);
                chk("t2_hold_s1", {24'h0, sd_r[15:8]}, 32'h12);
                chk("t2_bubble_v", {31'h0, sv_r[2]}, 0);
                chk("t2_bubble_d", {24'h0, sd_r[23:16]}, 0);
            end
            if (k >= 4 && k <= 7)
                chk("t2_gap", {31'h0, bus_r.out_valid},
                    (k == 4 || k == 7) ? 1 : 0);
            if (k == 7) chk("t2_resume", {24'h0, bus_r.out_data}, 32'h12);
            if (bus_r.in_valid && bus_r.in_ready) idx++;
        end
        bus_r.in_valid = 0;
        repeat (3) @(negedge clk);

        // flush stage 2 as 0xAA advances into it
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            bus_r.in_valid = (k == 0);
            bus_r.in_data  = 8'hAA;
            fl_r = (k == 2) ? 4'b0100 : 4'b0000;
            #1;
            if (k == 2) chk("t4_s1_aa", {24'h0, sd_r[15:8]}, 32'hAA);
            if (k == 3) begin
                chk("t4_s2_valid", {31'h0, sv_r[2]}, 0);
                chk("t4_s2_data", {24'h0, sd_r[23:16]}, 0);
                chk("t4_kill", {16'h0, kc_r}, 1);
            end
            if (k >= 1) chk("t4_no_aa", {31'h0, bus_r.out_valid}, 0);
        end

        // flush all with oldest stalled and consumer not ready
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            bus_r.in_valid  = (k < 4) || (k == 6);
            bus_r.in_data   = 8'(8'h31 + k);
            bus_r.out_ready = (k != 4) && (k != 6);
            st_r = (k == 4) ? 4'b1000 : 4'b0000;
            fl_r = (k == 4) ? 4'b1111 : 4'b0000;
            #1;
            if (k == 4) chk("t5_full", {28'h0, sv_r}, 32'hF);
            if (k == 5) begin
                chk("t5_cleared", {28'h0, sv_r}, 0);
                chk("t5_kill4", {16'h0, kc_r}, 5);
            end
            if (k == 6) chk("t5_rigid_block", {31'h0, bus_r.in_ready}, 0);
        end
        bus_r.in_valid  = 0;
        bus_r.out_ready = 1;

        // collapsing mode fills around a stuck oldest item
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus_c.out_ready = 0;
            bus_c.in_valid  = (k == 0) || (k >= 4);
            bus_c.in_data   = 8'(8'h50 + k);
            #1;
            if (k == 4) chk("t3_only_s3", {28'h0, sv_c}, 32'h8);
            if (k >= 4 && k <= 6)
                chk("t3_ready", {31'h0, bus_c.in_ready}, 1);
            if (k == 7) begin
                chk("t3_full_ready", {31'h0, bus_c.in_ready}, 0);
                chk("t3_full_occ", {29'h0, occ_c}, 4);
            end
        end
        bus_c.in_valid = 0;

        // kill counter saturation
        for (int k = 0; k < 23; k++) begin
            @(negedge clk);
            bus_s.in_valid = 1;
            bus_s.in_data  = 8'(k + 1);
            fl_s = 4'b0001;
            #1;
            chk("t6_kill_sat", {28'h0, kc_s}, (k < 15) ? k : 15);
            chk("t6_ready", {31'h0, bus_s.in_ready}, 1);
            if (k == 22) begin
                chk("t6_empty", {28'h0, sv_s} | {29'h0, occ_s}, 0);
                chk("t6_data", sd_s | {24'h0, bus_s.out_data}, 0);
                chk("t6_no_out", {31'h0, bus_s.out_valid}, 0);
            end
        end
        bus_s.in_valid = 0;
        fl_s = 0;

        // asynchronous reset in the middle of a stream
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus_r.in_valid = 1;
            bus_r.in_data  = 8'(8'h71 + k);
            #1;
        end
        chk("t7_pre_occ", {29'h0, occ_r}, 4);
        chk("t7_pre_kill", {16'h0, kc_r}, 5);
        rst = 1'b0;
        #1;
        chk("t7_out_valid", {31'h0, bus_r.out_valid}, 0);
        chk("t7_occ", {29'h0, occ_r}, 0);
        chk("t7_kill", {16'h0, kc_r}, 0);
        chk("t7_kill_s", {28'h0, kc_s}, 0);
        @(negedge clk);
        bus_r.in_valid = 0;
        rst = 1'b1;

        // randomised traffic on both modes
        tag_r = 8'd1;
        tag_c = 8'd1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            v    = ($urandom_range(0, 99) < 70);
            ordy = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) begin
                st_r[i] = ($urandom_range(0, 9) == 0);
                fl_r[i] = ($urandom_range(0, 24) == 0);
            end
            st_c = st_r;
            fl_c = fl_r;
            bus_r.in_valid = v;
            bus_c.in_valid = v;
            bus_r.in_data  = tag_r;
            bus_c.in_data  = tag_c;
            bus_r.out_ready = ordy;
            bus_c.out_ready = ordy;
            #1;
            if (bus_r.in_valid && bus_r.in_ready)
                tag_r = (tag_r == 8'hFF) ? 8'd1 : tag_r + 8'd1;
            if (bus_c.in_valid && bus_c.in_ready)
                tag_c = (tag_c == 8'hFF) ? 8'd1 : tag_c + 8'd1;
        end
        st_r = 0; fl_r = 0; st_c = 0; fl_c = 0;
        bus_r.in_valid = 0; bus_c.in_valid = 0;
        bus_r.out_ready = 1; bus_c.out_ready = 1;
        repeat (8) @(negedge clk);
        #3;
        chk("drain_r", {29'h0, occ_r}, 0);
        chk("drain_c", {29'h0, occ_c}, 0);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end
endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised chain of pipeline registers with per-stage valid bits.
- Each stage has its own stall (hold) and flush (bubble/kill) control.
- Generalises the fixed ID/EX/MEM/WB register bundle to any width and depth.
- Adds a rigid or bubble-collapsing mode, automatic bubble insertion behind stalled stages, ready/valid handshakes at both ends, an occupancy output and a saturating kill counter.
- Sits between producer and consumer datapath logic. The hazard unit drives stall/flush.

Parameters:
- WIDTH, 32: payload bits per stage.
- STAGES, 4: number of register stages (≥2). Stage 0 is youngest, stage STAGES-1 is oldest.
- COLLAPSE, 0: 0 = rigid (stalls propagate regardless of valid); 1 = bubble-collapsing (invalid stages never block).
- CNT_W, 16: kill counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  producer has an item.
- in_data  in  WIDTH  producer payload.
- in_ready  out  1  stage 0 loads this cycle.
- stall  in  STAGES  stall[i]: stage i holds its content.
- flush  in  STAGES  flush[i]: stage i becomes a bubble at the next edge.
- stage_valid  out  STAGES  registered valid bits.
- stage_data  out  STAGES*WIDTH  registered payloads; stage i occupies bits [i*WIDTH +: WIDTH].
- out_valid  out  1  oldest item offered.
- out_data  out  WIDTH  equals data of stage STAGES-1.
- out_ready  in  1  consumer accepts.
- occupancy  out  $clog2(STAGES+1)  popcount(stage_valid).
- kill_cnt  out  CNT_W  saturating count of valid items discarded by flush.

Behaviour:
- Reset (rst=0, async):
  - All valid bits, all data and kill_cnt are cleared to 0.
  - Consequently out_valid=0 and occupancy=0, without waiting for a clock edge.
  - Reset mid-stream discards everything and does not count as a kill.
- Output handshake:
  - out_valid = valid[S-1] & ~stall[S-1].
  - A transfer occurs when out_valid & out_ready.
- Blocking terms, evaluated combinationally, oldest stage first:
  - Rigid mode: blocked[S-1] = stall[S-1] | ~out_ready; blocked[i] = stall[i] | blocked[i+1].
  - Collapse mode: blocked[S-1] = stall[S-1] | (valid[S-1] & ~out_ready); blocked[i] = stall[i] | (valid[i] & blocked[i+1]).
- in_ready = ~blocked[0].
  - No combinational path from in_valid to in_ready.
- Incoming item per stage:
  - Stage 0: inc_v = in_valid, inc_d = in_data.
  - Stage i≥1: inc_v = valid[i-1] & ~blocked[i-1], inc_d = data[i-1].
  - When stage i-1 is blocked and stage i is not, stage i loads a bubble. This guarantees no duplicated items.
- Next state of stage i, in priority order:
  1. flush[i]: valid←0, data←0. The incoming item is discarded; if stage i is blocked, its own held content is discarded instead.
  2. blocked[i]: hold valid and data.
  3. Otherwise: valid←inc_v; data←inc_d when inc_v, else data←0.
- Flush does not change blocked[]. Upstream stages still advance into the flushed slot, and that item is killed.
- kill_cnt increments by the number of valid items discarded in the cycle. Per stage i, an item is discarded when:
  - flush[i] & blocked[i] & valid[i], or
  - flush[i] & ~blocked[i] & inc_v.
  - Several kills in one cycle add together. The counter saturates at 2^CNT_W-1 and never wraps.
- Latency:
  - An item accepted at edge k occupies stage j after edge k+j.
  - With no stalls it is offered on out_valid in the cycle after edge k+STAGES-1.
  - Throughput is 1 item/cycle.
- Simultaneous events:
  - stall[i] and flush[i] together: flush wins (the held item is killed).
  - An output transfer and flush[S-1] in the same cycle: the item transfers, because out_valid is computed from the current state. It is not counted as a kill, since stage S-1 is not blocked.
  - A killed in_valid still consumes the handshake (in_ready=1).

Test Plan:
- STAGES=4, WIDTH=8, rigid, out_ready=1; accept 0x01..0x08 on consecutive edges -> 0x01 offered on out in the cycle after the 4th edge, then one item per cycle in order; occupancy=4 in steady state.
- Rigid; stall[1]=1 for 2 cycles mid-stream -> in_ready=0 for those 2 cycles; stages 0–1 hold; stage 2 loads 2 bubbles (data 0); output shows a 2-cycle gap; no item lost or duplicated.
- COLLAPSE=1; only stage 3 valid, out_ready=0, in_valid=1 every cycle -> in_ready stays 1 until all 4 stages are valid; then in_ready=0 and occupancy=4. Rigid mode gives in_ready=0 immediately.
- flush[2] while stage 1 holds 0xAA and advances -> 0xAA never appears; stage_valid[2]=0, stage 2 data=0x00; kill_cnt increments by 1.
- flush=4'b1111 with all four stages valid and stall[3]=1, out_ready=0 -> all four stages clear; kill_cnt increments by 4 in one cycle.
- CNT_W=4, 20 kills -> kill_cnt=15 and holds. Assert rst=0 between edges mid-stream -> out_valid, occupancy and kill_cnt read 0 immediately, before the next edge.
